alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Same 16-op select map, but with these additions:
  - generic WIDTH;
  - valid/ready handshake on input and output;
  - registered result plus status flags;
  - multi-cycle restoring divider in place of a combinational "/".
- Sits between an operand-issuing sequencer and a result consumer that may apply backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (minimum 2).
- SHW, $clog2(WIDTH), width of the shift/rotate amount taken from b[SHW-1:0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and sel presented.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- sel  input  4  operation select.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  WIDTH  result.
- flag_z  output  1  out == 0.
- flag_c  output  1  add: carry out; sub: borrow (a < b); else 0.
- flag_v  output  1  add/sub signed (two's-complement) overflow; else 0.
- flag_dz  output  1  divide by zero occurred (sel 0011, b == 0).

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; out=0; out_valid=0; all flags 0; divider registers cleared.
  - Reset mid-divide abandons the operation; no result is ever presented for it.
- Acceptance: transfer when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept and drain may occur in the same cycle.
- Op map (sel):
  - 0000 a+b; 0001 a-b; 0010 a*b (low WIDTH bits); 0011 a/b (quotient).
  - 0100 a<<b; 0101 a>>b. Logical shifts; if b >= WIDTH the result is 0.
  - 0110 rotate-left a by b mod WIDTH; 0111 rotate-right a by b mod WIDTH.
  - 1000 and; 1001 or; 1010 xor; 1011 nor; 1100 nand; 1101 xnor.
  - 1110 (a>b) and 1111 (a==b): result is 1 zero-extended to WIDTH, else 0.
- FSM states: IDLE, DIV, DONE.
  - IDLE:
    - Accepting a non-divide op computes the result and registers it into out/flags.
    - out_valid rises next cycle; latency 1.
    - Accepting a divide with b != 0 loads the divider and goes to DIV.
    - Accepting a divide with b == 0 registers out=all-ones and flag_dz=1; latency 1; stays IDLE.
  - DIV: restoring divide, one quotient bit per cycle, WIDTH cycles. Then DONE.
  - DONE:
    - Writes the quotient to out and sets out_valid; flag_z computed, flag_c/v/dz=0.
    - Returns to IDLE. Total divide latency = WIDTH+1 cycles from accept to out_valid.
- Output hold: while out_valid && !out_ready, out and flags are stable and in_ready=0.
- out_valid falls the cycle after out_ready, unless a new result is written in the same cycle.
- in_ready=0 throughout DIV and DONE regardless of out_ready.
- Flags are registered together with out and refer only to the current result.
- Arithmetic wraps modulo 2^WIDTH; flag_c and flag_v report loss as defined above.

Optional Feature:
- ALU_SAT_EN defined: saturating add and sub.
  - sel 0000 clamps to all-ones on carry out.
  - sel 0001 clamps to 0 on borrow.
  - flag_c/flag_v still report the unclamped condition.
- Not defined: add/sub wrap modulo 2^WIDTH.
- All other ops are identical in both builds.

Test Plan:
- WIDTH=8, a=200, b=100, sel=0000 -> 1 cycle later out=44, flag_c=1, flag_z=0. With ALU_SAT_EN: out=255, flag_c=1.
- a=200, b=7, sel=0011 -> in_ready=0 for the divide. out_valid exactly 9 cycles after accept with out=28. Next op is accepted the cycle out_ready is seen.
- a=5, b=0, sel=0011 -> next cycle out=255, flag_dz=1. Then a=3, b=3, sel=1111 -> out=1, flag_dz=0.
- a=0x81, b=1, sel=0110 -> out=0x03. Then b=9, sel=0100, a=0xFF -> out=0, flag_z=1.
- out_ready held 0 for 5 cycles after a result (a=0x70, b=0x70, sel=0000 -> out=0xE0, flag_v=1):
  - out/flags stable and in_ready=0 throughout;
  - raising out_ready with in_valid high accepts the next op in that cycle.
- rst_n pulsed low for 1 cycle during DIV (cycle 3 of 8) -> out_valid=0, out=0, in_ready=1 after release; no stale quotient ever appears.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered, handshaked ALU with a 16-op select map and a multi-cycle restoring divider.
// Latency: 1 cycle for all ops except a non-zero divide, which takes WIDTH+1 cycles.
// Backpressure: in_ready drops while a result is held unread or a divide is in flight.
// Optional feature: define ALU_SAT_EN for saturating add/sub (clamp on carry/borrow).
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz
);

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             is_div;
    logic             div_zero;
    logic             div_start;
    logic             quick_wr;
    logic             div_wr;

    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rot_amt;
    logic             shift_big;

    logic [WIDTH-1:0] dv_rem, dv_quo, dv_dvs;
    logic [CW-1:0]    dv_cnt;
    logic [WIDTH-1:0] dv_rem_in, dv_quo_in, dv_dvs_in;
    logic [WIDTH-1:0] dv_rem_nxt, dv_quo_nxt;
    logic [WIDTH:0]   dv_shift, dv_trial;

    // A new op is taken only from IDLE and only if any held result leaves this cycle.
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_div    = (sel == 4'b0011);
    assign div_zero  = (b == '0);
    assign div_start = accept && is_div && !div_zero;
    assign quick_wr  = accept && !div_start;
    assign div_wr    = (state == DONE);

    assign sum       = {1'b0, a} + {1'b0, b};
    assign diff      = {1'b0, a} - {1'b0, b};
    assign rot_amt   = b % W_VAL;
    assign shift_big = (b >= W_VAL);

    // Single-cycle result and carry/overflow for every op; divide-by-zero yields all-ones.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (sel)
            4'b0000: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (sum[WIDTH]) res = '1;
`endif
            end
            4'b0001: begin
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (diff[WIDTH]) res = '0;
`endif
            end
            4'b0010: res = a * b;
            4'b0011: res = '1;
            4'b0100: res = shift_big ? '0 : (a << b[SHW-1:0]);
            4'b0101: res = shift_big ? '0 : (a >> b[SHW-1:0]);
            4'b0110: res = (a << rot_amt) | (a >> (W_VAL - rot_amt));
            4'b0111: res = (a >> rot_amt) | (a << (W_VAL - rot_amt));
            4'b1000: res = a & b;
            4'b1001: res = a | b;
            4'b1010: res = a ^ b;
            4'b1011: res = ~(a | b);
            4'b1100: res = ~(a & b);
            4'b1101: res = ~(a ^ b);
            4'b1110: res = {{(WIDTH-1){1'b0}}, (a > b)};
            4'b1111: res = {{(WIDTH-1){1'b0}}, (a == b)};
        endcase
    end

    // One restoring-divide step; the accept cycle runs the first step straight off the operands.
    always_comb begin
        if (state == IDLE) begin
            dv_rem_in = '0;
            dv_quo_in = a;
            dv_dvs_in = b;
        end else begin
            dv_rem_in = dv_rem;
            dv_quo_in = dv_quo;
            dv_dvs_in = dv_dvs;
        end
        dv_shift = {dv_rem_in, dv_quo_in[WIDTH-1]};
        dv_trial = dv_shift - {1'b0, dv_dvs_in};
        if (dv_trial[WIDTH]) begin
            dv_rem_nxt = dv_shift[WIDTH-1:0];
        end else begin
            dv_rem_nxt = dv_trial[WIDTH-1:0];
        end
        dv_quo_nxt = {dv_quo_in[WIDTH-2:0], ~dv_trial[WIDTH]};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: DIV covers the remaining WIDTH-1 quotient bits, DONE publishes the quotient.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (div_start) state_nxt = DIV;
            DIV:     if (dv_cnt == LAST_CNT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Divider working registers; count tracks quotient bits already produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_rem <= '0;
            dv_quo <= '0;
            dv_dvs <= '0;
            dv_cnt <= '0;
        end else if (div_start) begin
            dv_rem <= dv_rem_nxt;
            dv_quo <= dv_quo_nxt;
            dv_dvs <= b;
            dv_cnt <= CW'(1);
        end else if (state == DIV) begin
            dv_rem <= dv_rem_nxt;
            dv_quo <= dv_quo_nxt;
            dv_cnt <= dv_cnt + CW'(1);
        end
    end

    // Output register: result and flags are written together and held until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_dz   <= 1'b0;
            out_valid <= 1'b0;
        end else if (quick_wr) begin
            out       <= res;
            flag_z    <= (res == '0);
            flag_c    <= res_c;
            flag_v    <= res_v;
            flag_dz   <= is_div;
            out_valid <= 1'b1;
        end else if (div_wr) begin
            out       <= dv_quo;
            flag_z    <= (dv_quo == '0);
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_dz   <= 1'b0;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=8: directed scenarios plus randomized ops.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge (+1 for comb).
// Expected values come from an integer-arithmetic model of the op table.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;
    logic         flag_z, flag_c, flag_v, flag_dz;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_dz   (flag_dz)
    );

    // Reference: {out[7:0], z, c, v, dz} from plain integer arithmetic.
    function automatic logic [11:0] model(input int av, input int bv, input int sv);
        int r, sa, sb, k;
        logic c, v, dz;
        r = 0; c = 1'b0; v = 1'b0; dz = 1'b0;
        sa = (av >= 128) ? av - 256 : av;
        sb = (bv >= 128) ? bv - 256 : bv;
        k  = bv % 8;
        case (sv)
            0: begin
                r = (av + bv) % 256;
                c = (av + bv) > 255;
                v = (sa + sb > 127) || (sa + sb < -128);
`ifdef ALU_SAT_EN
                if (c) r = 255;
`endif
            end
            1: begin
                r = (av - bv + 256) % 256;
                c = av < bv;
                v = (sa - sb > 127) || (sa - sb < -128);
`ifdef ALU_SAT_EN
                if (c) r = 0;
`endif
            end
            2: r = (av * bv) % 256;
            3: begin
                if (bv == 0) begin r = 255; dz = 1'b1; end
                else r = av / bv;
            end
            4: r = (bv >= 8) ? 0 : ((av << bv) % 256);
            5: r = (bv >= 8) ? 0 : (av >> bv);
            6: r = ((av << k) | (av >> (8 - k))) % 256;
            7: r = ((av >> k) | (av << (8 - k))) % 256;
            8: r = av & bv;
            9: r = av | bv;
            10: r = av ^ bv;
            11: r = 255 - (av | bv);
            12: r = 255 - (av & bv);
            13: r = 255 - (av ^ bv);
            14: r = (av > bv) ? 1 : 0;
            15: r = (av == bv) ? 1 : 0;
            default: r = 0;
        endcase
        return {r[7:0], (r == 0), c, v, dz};
    endfunction

    // Present one op from a falling edge and hold it until accepted; returns one cycle after accept.
    task automatic issue(input int av, input int bv, input int sv, output bit ok);
        a = 8'(av); b = 8'(bv); sel = 4'(sv);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        for (int ph = 0; ph < 2; ph++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid ph%0d: got %b want 0", ph, out_valid); end
            checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out ph%0d: got %h want 00", ph, out); end
            checks++; if ({flag_z, flag_c, flag_v, flag_dz} !== 4'b0000) begin errors++; $display("FAIL reset_flags ph%0d: got %b want 0000", ph, {flag_z, flag_c, flag_v, flag_dz}); end
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready ph%0d: got %b want 1", ph, in_ready); end
            if (ph == 0) begin
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_add();
        bit ok;
        logic [7:0] want;
`ifdef ALU_SAT_EN
        want = 8'd255;
`else
        want = 8'd44;
`endif
        out_ready = 1'b0;
        issue(200, 100, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_accept: not accepted"); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
        checks++; if (out !== want) begin errors++; $display("FAIL add_out: got %0d want %0d", out, want); end
        checks++; if ({flag_z, flag_c} !== 2'b01) begin errors++; $display("FAIL add_flags zc: got %b want 01", {flag_z, flag_c}); end
        drain();
    endtask

    task automatic test_div();
        bit ok;
        int cyc, busy;
        out_ready = 1'b0;
        issue(200, 7, 3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL div_accept: not accepted"); end
        cyc = 0; busy = 0;
        while (!out_valid && cyc < 20) begin
            if (in_ready !== 1'b0) busy++;
            @(negedge clk);
            cyc++;
        end
        checks++; if (busy != 0) begin errors++; $display("FAIL div_in_ready: high in %0d divide cycles, want 0", busy); end
        checks++; if (cyc + 1 != 9) begin errors++; $display("FAIL div_latency: got %0d want 9", cyc + 1); end
        checks++; if (out !== 8'd28) begin errors++; $display("FAIL div_out: got %0d want 28", out); end
        out_ready = 1'b1;
        a = 8'd3; b = 8'd3; sel = 4'hF; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL div_next_ready: got %b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if ({out_valid, out} !== {1'b1, 8'd1}) begin errors++; $display("FAIL div_next_out: got %b/%0d want 1/1", out_valid, out); end
        drain();
    endtask

    task automatic test_div_zero();
        bit ok;
        out_ready = 1'b0;
        issue(5, 0, 3, ok);
        checks++; if ({out, flag_dz, flag_z} !== {8'd255, 1'b1, 1'b0}) begin errors++; $display("FAIL dz_out: got %0d dz=%b z=%b want 255 dz=1 z=0", out, flag_dz, flag_z); end
        out_ready = 1'b1;
        issue(3, 3, 15, ok);
        checks++; if ({ok, out, flag_dz} !== {1'b1, 8'd1, 1'b0}) begin errors++; $display("FAIL dz_follow: got ok=%b out=%0d dz=%b want 1/1/0", ok, out, flag_dz); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_rot_shift();
        bit ok;
        out_ready = 1'b0;
        issue(8'h81, 1, 6, ok);
        checks++; if (out !== 8'h03) begin errors++; $display("FAIL rotl_out: got %h want 03", out); end
        drain();
        issue(8'hFF, 9, 4, ok);
        checks++; if ({out, flag_z} !== {8'h00, 1'b1}) begin errors++; $display("FAIL shl_big: got %h z=%b want 00 z=1", out, flag_z); end
        drain();
    endtask

    task automatic test_hold();
        bit ok;
        int bad;
        logic [11:0] held;
        out_ready = 1'b0;
        issue(8'h70, 8'h70, 0, ok);
        held = {out, flag_z, flag_c, flag_v, flag_dz};
        checks++; if (held !== {8'hE0, 4'b0010}) begin errors++; $display("FAIL hold_first: got %h want %h", held, {8'hE0, 4'b0010}); end
        a = 8'h0F; b = 8'h01; sel = 4'h1; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
            if ({out, flag_z, flag_c, flag_v, flag_dz} !== held) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable: %0d violations want 0", bad); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if ({out_valid, out} !== {1'b1, 8'h0E}) begin errors++; $display("FAIL hold_next: got %b/%h want 1/0e", out_valid, out); end
        drain();
    endtask

    task automatic test_reset_mid_div();
        bit ok;
        int bad;
        out_ready = 1'b0;
        issue(200, 7, 3, ok);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if ({out_valid, out, in_ready} !== {1'b0, 8'h00, 1'b1}) begin errors++; $display("FAIL rstdiv_state: got v=%b out=%h rdy=%b want 0/00/1", out_valid, out, in_ready); end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstdiv_stale: out_valid high %0d cycles want 0", bad); end
    endtask

    task automatic test_random();
        bit ok;
        int av, bv, sv, r, cyc, lat;
        logic [11:0] exp, got;
        for (int i = 0; i < 120; i++) begin
            av = $urandom_range(0, 255);
            sv = $urandom_range(0, 15);
            r  = $urandom_range(0, 9);
            if (r == 0) bv = 0;
            else if (r < 4) bv = $urandom_range(0, 15);
            else bv = $urandom_range(0, 255);
            if (r == 9) bv = av;
            exp = model(av, bv, sv);
            lat = (sv == 3 && bv != 0) ? 9 : 1;
            out_ready = 1'b0;
            issue(av, bv, sv, ok);
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            checks++; if (!ok || cyc + 1 != lat) begin errors++; $display("FAIL rand_latency #%0d sel=%0d: ok=%b got %0d want %0d", i, sv, ok, cyc + 1, lat); end
            got = {out, flag_z, flag_c, flag_v, flag_dz};
            checks++; if (got !== exp) begin errors++; $display("FAIL rand_result #%0d a=%0d b=%0d sel=%0d: got %h want %h", i, av, bv, sv, got, exp); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drain();
        end
    endtask

    task automatic test_back_to_back();
        int av, bv, sv;
        logic [11:0] pexp, got;
        pexp = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            av = $urandom_range(0, 255);
            bv = $urandom_range(0, 255);
            sv = $urandom_range(0, 15);
            if (sv == 3) sv = 2;
            a = 8'(av); b = 8'(bv); sel = 4'(sv); in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready #%0d: got %b want 1", i, in_ready); end
            if (i > 0) begin
                got = {out, flag_z, flag_c, flag_v, flag_dz};
                checks++; if (out_valid !== 1'b1 || got !== pexp) begin errors++; $display("FAIL b2b_result #%0d: got v=%b %h want 1 %h", i - 1, out_valid, got, pexp); end
            end
            pexp = model(av, bv, sv);
            @(negedge clk);
        end
        in_valid = 1'b0;
        got = {out, flag_z, flag_c, flag_v, flag_dz};
        checks++; if (out_valid !== 1'b1 || got !== pexp) begin errors++; $display("FAIL b2b_last: got v=%b %h want 1 %h", out_valid, got, pexp); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_div();
        test_div_zero();
        test_rot_shift();
        test_hold();
        test_reset_mid_div();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
